// File: rtl/r4mdc_pkg.sv
// Shared types and helpers for the R4MDC FFT stage sequencer.
package r4mdc_pkg;

    localparam int unsigned MAX_STAGES = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_e;

    // n low-order ones, never more than width bits set
    function automatic logic [MAX_STAGES-1:0] therm(input int unsigned n, input int unsigned width);
        logic [MAX_STAGES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_STAGES; i++) begin
            r[i] = (i < n) && (i < width);
        end
        return r;
    endfunction

endpackage

// File: rtl/r4mdc_stage_sequencer_if.sv
// Control/status bundle between the R4MDC sequencer and its pipeline stages.
interface r4mdc_stage_sequencer_if #(
    parameter int unsigned NUM_STAGES = 2
);
    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] enable;
    logic [2:0]            stage_idx;
    logic                  busy;
    logic                  done;
    logic                  error;

    // Environment side: issues start/abort, reports butterfly valids
    modport master (
        output start, abort, stage_valid,
        input  enable, stage_idx, busy, done, error
    );

    // Sequencer side
    modport slave (
        input  start, abort, stage_valid,
        output enable, stage_idx, busy, done, error
    );
endinterface

// File: rtl/r4mdc_cycle_counter.sv
// Saturating up-counter with synchronous clear; holds once it reaches terminal.
module r4mdc_cycle_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    // Clear wins over increment; stop at terminal so the count never wraps
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != terminal)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/r4mdc_stage_sequencer.sv
// Brings R4MDC FFT stages online one at a time, drains the pipeline, flags frame done.
// NUM_STAGES legal 1..8, DRAIN_LEN legal 1..65535, TIMEOUT=0 disables the watchdog.
module r4mdc_stage_sequencer
    import r4mdc_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned DRAIN_LEN  = 16,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned CONTINUOUS = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    r4mdc_stage_sequencer_if.slave bus
);
    localparam int unsigned          DRAIN_W    = $clog2(DRAIN_LEN + 1);
    localparam bit                   WD_ON      = (TIMEOUT != 0);
    localparam int unsigned          WD_W       = WD_ON ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);
    localparam logic [WD_W-1:0]      WD_LAST    = WD_ON ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [2:0]           LAST_STAGE = 3'(NUM_STAGES - 1);

    state_e                  state_q, state_d;
    logic [2:0]              stage_q, stage_d;
    logic [NUM_STAGES-1:0]   enable_q, enable_d;
    logic [2:0]              stage_idx_q, stage_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    drain_clr, drain_en;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic                    wd_clr, wd_en;
    logic [WD_W-1:0]         wd_cnt;
    logic [MAX_STAGES-1:0]   valid_pad;
    logic [MAX_STAGES-1:0]   therm_v;
    logic                    cur_valid, drain_last, wd_expire;

    r4mdc_cycle_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (drain_clr),
        .en       (drain_en),
        .terminal (DRAIN_LAST),
        .count    (drain_cnt)
    );

    if (WD_ON) begin : g_wd
        r4mdc_cycle_counter #(.WIDTH(WD_W)) u_wd_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (wd_clr),
            .en       (wd_en),
            .terminal (WD_LAST),
            .count    (wd_cnt)
        );
    end else begin : g_no_wd
        logic unused_wd;
        assign unused_wd = wd_clr ^ wd_en;
        assign wd_cnt    = '0;
    end

    // Only the awaited stage's valid bit matters; pad so a 3-bit index is always legal
    always_comb begin
        valid_pad                   = '0;
        valid_pad[NUM_STAGES-1:0]   = bus.stage_valid;
        cur_valid                   = valid_pad[stage_q];
        drain_last                  = (drain_cnt == DRAIN_LAST);
        wd_expire                   = WD_ON && (wd_cnt == WD_LAST);
    end

    // Next state and counter control; abort > watchdog > valid/drain end > start
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        drain_clr = 1'b0;
        drain_en  = 1'b0;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        if (bus.abort) begin
            state_d   = IDLE;
            stage_d   = '0;
            drain_clr = 1'b1;
            wd_clr    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    stage_d   = '0;
                    drain_clr = 1'b1;
                    wd_clr    = 1'b1;
                    if (bus.start) state_d = FILL;
                end
                FILL: begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                        stage_d = '0;
                        wd_clr  = 1'b1;
                    end else if (cur_valid) begin
                        wd_clr = 1'b1;
                        if (stage_q == LAST_STAGE) begin
                            state_d   = DRAIN;
                            stage_d   = '0;
                            drain_clr = 1'b1;
                        end else begin
                            stage_d = stage_q + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    drain_en = 1'b1;
                    if (drain_last) begin
                        done_d    = 1'b1;
                        drain_clr = 1'b1;
                        // Continuous mode re-arms the drain with enables held
                        if (!((CONTINUOUS != 0) && bus.start)) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs derived from the next state so they line up with it
    always_comb begin
        therm_v     = therm(32'(stage_d) + 32'd1, NUM_STAGES);
        enable_d    = '0;
        stage_idx_d = '0;
        busy_d      = (state_d != IDLE);
        if (state_d == FILL) begin
            enable_d    = therm_v[NUM_STAGES-1:0];
            stage_idx_d = stage_d;
        end else if (state_d == DRAIN) begin
            enable_d = '1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            enable_q    <= '0;
            stage_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            enable_q    <= enable_d;
            stage_idx_q <= stage_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.enable    = enable_q;
    assign bus.stage_idx = stage_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_r4mdc_stage_sequencer.sv
// Bench for r4mdc_stage_sequencer: three configurations, timeline-based expectations.
// Cycle c is the interval after clock edge c-1; inputs driven in cycle c are sampled at edge c.
module tb_r4mdc_stage_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int sel          = 0;

    logic       drv_start, drv_abort;
    logic [7:0] drv_valid;

    // a: 2 stages, watchdog 64; b: same but continuous; c: 4 stages, short drain, no watchdog
    r4mdc_stage_sequencer_if #(.NUM_STAGES(2)) a_if ();
    r4mdc_stage_sequencer_if #(.NUM_STAGES(2)) b_if ();
    r4mdc_stage_sequencer_if #(.NUM_STAGES(4)) c_if ();

    assign a_if.start       = (sel == 0) && drv_start;
    assign a_if.abort       = (sel == 0) && drv_abort;
    assign a_if.stage_valid = (sel == 0) ? drv_valid[1:0] : 2'b00;
    assign b_if.start       = (sel == 1) && drv_start;
    assign b_if.abort       = (sel == 1) && drv_abort;
    assign b_if.stage_valid = (sel == 1) ? drv_valid[1:0] : 2'b00;
    assign c_if.start       = (sel == 2) && drv_start;
    assign c_if.abort       = (sel == 2) && drv_abort;
    assign c_if.stage_valid = (sel == 2) ? drv_valid[3:0] : 4'b0000;

    r4mdc_stage_sequencer #(.NUM_STAGES(2), .DRAIN_LEN(16), .TIMEOUT(64), .CONTINUOUS(0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );
    r4mdc_stage_sequencer #(.NUM_STAGES(2), .DRAIN_LEN(16), .TIMEOUT(64), .CONTINUOUS(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );
    r4mdc_stage_sequencer #(.NUM_STAGES(4), .DRAIN_LEN(5), .TIMEOUT(0), .CONTINUOUS(0)) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (c_if)
    );

    logic [7:0] obs_en;
    logic [2:0] obs_idx;
    logic       obs_busy, obs_done, obs_error;

    // Route the selected DUT's outputs to one observation point
    always_comb begin
        obs_en    = {6'b0, a_if.enable};
        obs_idx   = a_if.stage_idx;
        obs_busy  = a_if.busy;
        obs_done  = a_if.done;
        obs_error = a_if.error;
        if (sel == 1) begin
            obs_en    = {6'b0, b_if.enable};
            obs_idx   = b_if.stage_idx;
            obs_busy  = b_if.busy;
            obs_done  = b_if.done;
            obs_error = b_if.error;
        end else if (sel == 2) begin
            obs_en    = {4'b0, c_if.enable};
            obs_idx   = c_if.stage_idx;
            obs_busy  = c_if.busy;
            obs_done  = c_if.done;
            obs_error = c_if.error;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({a_if.enable, a_if.stage_idx, a_if.busy, a_if.done, a_if.error} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_a: got en=%b idx=%0d busy=%b done=%b err=%b, expected all 0",
                     a_if.enable, a_if.stage_idx, a_if.busy, a_if.done, a_if.error);
        end
        tests_run++;
        if ({b_if.enable, b_if.stage_idx, b_if.busy, b_if.done, b_if.error} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_b: got en=%b idx=%0d busy=%b done=%b err=%b, expected all 0",
                     b_if.enable, b_if.stage_idx, b_if.busy, b_if.done, b_if.error);
        end
        tests_run++;
        if ({c_if.enable, c_if.stage_idx, c_if.busy, c_if.done, c_if.error} !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_c: got en=%b idx=%0d busy=%b done=%b err=%b, expected all 0",
                     c_if.enable, c_if.stage_idx, c_if.busy, c_if.done, c_if.error);
        end
        #10;
        rst_n = 1'b1;
        step();
    endtask

    // One frame from a start pulse; stage k waits w[k] cycles before its valid.
    // chain: hold start across the drain end and return at the done cycle so the
    // next call launches its frame from there.
    task automatic run_frame(input string name, input int s, input int n, input int dl,
                             input int w0, input int w1, input bit rnd, input bit noise,
                             input bit chain);
        int         w[8];
        int         e[9];
        int         d, tot, st;
        logic [7:0] exp_en, v;
        logic [2:0] exp_idx;
        logic       exp_busy, exp_done;
        sel = s;
        for (int k = 0; k < n; k++) w[k] = rnd ? int'($urandom_range(0, 20)) : (k == 0 ? w0 : w1);
        e[0] = 1;
        for (int k = 0; k < n; k++) e[k+1] = e[k] + w[k] + 1;
        d   = e[n];
        tot = d + dl;
        drv_abort = 1'b0;
        drv_start = 1'b1;
        drv_valid = noise ? 8'($urandom) : 8'h00;
        step();
        for (int c = 1; c <= tot + 1; c++) begin
            st = 0;
            for (int k = 0; k < n; k++) if (e[k] <= c) st = k;
            if (c < d) begin
                exp_en = 8'((1 << (st + 1)) - 1); exp_idx = 3'(st); exp_busy = 1; exp_done = 0;
            end else if (c < tot) begin
                exp_en = 8'((1 << n) - 1); exp_idx = 0; exp_busy = 1; exp_done = 0;
            end else if (c == tot) begin
                exp_en = 0; exp_idx = 0; exp_busy = 0; exp_done = 1;
            end else begin
                exp_en = 0; exp_idx = 0; exp_busy = 0; exp_done = 0;
            end
            tests_run++;
            if ({obs_en, obs_idx, obs_busy, obs_done, obs_error} !==
                {exp_en, exp_idx, exp_busy, exp_done, 1'b0}) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got en=%h idx=%0d busy=%b done=%b err=%b, expected en=%h idx=%0d busy=%b done=%b err=0",
                         name, c, obs_en, obs_idx, obs_busy, obs_done, obs_error,
                         exp_en, exp_idx, exp_busy, exp_done);
            end
            if (chain && c == tot) return;
            v = noise ? 8'($urandom) : 8'h00;
            if (c < d) v[st] = (c == e[st] + w[st]);
            drv_valid = v;
            if (chain && c >= tot - 3) drv_start = 1'b1;
            else drv_start = (noise && c < tot) ? 1'($urandom) : 1'b0;
            step();
        end
        drv_valid = 8'h00;
        drv_start = 1'b0;
    endtask

    // No valid for the awaited stage (the other bit held high): error after TIMEOUT cycles
    task automatic test_watchdog(input bit adv, input int w0);
        int         e1, err_c;
        logic [7:0] exp_en;
        logic [2:0] exp_idx;
        logic       exp_busy, exp_err;
        sel  = 0;
        e1   = w0 + 2;
        err_c = adv ? e1 + 64 : 65;
        drv_start = 1'b1;
        drv_valid = 8'h00;
        step();
        drv_start = 1'b0;
        for (int c = 1; c <= err_c + 1; c++) begin
            if (c < err_c) begin
                exp_busy = 1; exp_err = 0;
                if (adv && c >= e1) begin exp_en = 8'h03; exp_idx = 1; end
                else begin exp_en = 8'h01; exp_idx = 0; end
            end else begin
                exp_en = 0; exp_idx = 0; exp_busy = 0; exp_err = (c == err_c);
            end
            tests_run++;
            if ({obs_en, obs_idx, obs_busy, obs_done, obs_error} !==
                {exp_en, exp_idx, exp_busy, 1'b0, exp_err}) begin
                tests_failed++;
                $display("FAIL watchdog adv=%0d cycle %0d: got en=%h idx=%0d busy=%b done=%b err=%b, expected en=%h idx=%0d busy=%b done=0 err=%b",
                         adv, c, obs_en, obs_idx, obs_busy, obs_done, obs_error,
                         exp_en, exp_idx, exp_busy, exp_err);
            end
            if (adv && c >= e1) drv_valid = 8'h01;
            else drv_valid = (adv && c == w0 + 1) ? 8'h03 : 8'h02;
            step();
        end
        drv_valid = 8'h00;
    endtask

    // Nominal frame (valids at 5 and 12) aborted at cycle 13+off
    task automatic test_abort(input int off);
        int         ac;
        logic [7:0] exp_en;
        logic [2:0] exp_idx;
        logic       exp_busy;
        sel = 0;
        ac  = 13 + off;
        drv_start = 1'b1;
        drv_valid = 8'h00;
        step();
        drv_start = 1'b0;
        for (int c = 1; c <= ac + 20; c++) begin
            if (c > ac) begin exp_en = 0; exp_idx = 0; exp_busy = 0; end
            else if (c < 6) begin exp_en = 8'h01; exp_idx = 0; exp_busy = 1; end
            else if (c < 13) begin exp_en = 8'h03; exp_idx = 1; exp_busy = 1; end
            else begin exp_en = 8'h03; exp_idx = 0; exp_busy = 1; end
            tests_run++;
            if ({obs_en, obs_idx, obs_busy, obs_done, obs_error} !==
                {exp_en, exp_idx, exp_busy, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL abort off=%0d cycle %0d: got en=%h idx=%0d busy=%b done=%b err=%b, expected en=%h idx=%0d busy=%b done=0 err=0",
                         off, c, obs_en, obs_idx, obs_busy, obs_done, obs_error,
                         exp_en, exp_idx, exp_busy);
            end
            drv_valid = (c == 5) ? 8'h01 : (c == 12) ? 8'h02 : 8'h00;
            drv_abort = (c == ac);
            step();
        end
        drv_abort = 1'b0;
        drv_valid = 8'h00;
    endtask

    // Start held high: three back-to-back drains, start dropped before the last one ends
    task automatic test_continuous();
        int         w0, w1, e1, d;
        logic [7:0] exp_en;
        logic [2:0] exp_idx;
        logic       exp_busy, exp_done;
        sel = 1;
        w0  = int'($urandom_range(0, 20));
        w1  = int'($urandom_range(0, 20));
        e1  = 1 + w0 + 1;
        d   = e1 + w1 + 1;
        drv_start = 1'b1;
        drv_valid = 8'h00;
        step();
        for (int c = 1; c <= d + 49; c++) begin
            exp_done = (c == d + 16) || (c == d + 32) || (c == d + 48);
            if (c < e1) begin exp_en = 8'h01; exp_idx = 0; exp_busy = 1; end
            else if (c < d) begin exp_en = 8'h03; exp_idx = 1; exp_busy = 1; end
            else if (c < d + 48) begin exp_en = 8'h03; exp_idx = 0; exp_busy = 1; end
            else begin exp_en = 0; exp_idx = 0; exp_busy = 0; end
            tests_run++;
            if ({obs_en, obs_idx, obs_busy, obs_done, obs_error} !==
                {exp_en, exp_idx, exp_busy, exp_done, 1'b0}) begin
                tests_failed++;
                $display("FAIL continuous cycle %0d: got en=%h idx=%0d busy=%b done=%b err=%b, expected en=%h idx=%0d busy=%b done=%b err=0",
                         c, obs_en, obs_idx, obs_busy, obs_done, obs_error,
                         exp_en, exp_idx, exp_busy, exp_done);
            end
            drv_valid = (c == w0 + 1) ? 8'h01 : (c == e1 + w1) ? 8'h02 : 8'h00;
            drv_start = (c < d + 32);
            step();
        end
        drv_start = 1'b0;
        drv_valid = 8'h00;
    endtask

    // Four-stage DUT: reach stage 2, then assert reset between clock edges
    task automatic test_reset_mid_fill();
        logic [7:0] exp_tab [6];
        exp_tab = '{8'h00, 8'h01, 8'h03, 8'h03, 8'h07, 8'h07};
        sel = 2;
        drv_start = 1'b1;
        drv_valid = 8'h00;
        step();
        drv_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tests_run++;
            if ({obs_en, obs_busy, obs_error} !== {exp_tab[c], 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL four_stage_fill cycle %0d: got en=%h busy=%b err=%b, expected en=%h busy=1 err=0",
                         c, obs_en, obs_busy, obs_error, exp_tab[c]);
            end
            drv_valid = (c == 1) ? 8'h01 : (c == 3) ? 8'h02 : 8'h00;
            if (c < 5) step();
        end
        drv_valid = 8'h00;
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({obs_en, obs_idx, obs_busy, obs_done, obs_error} !== 14'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got en=%h idx=%0d busy=%b done=%b err=%b, expected all 0",
                     obs_en, obs_idx, obs_busy, obs_done, obs_error);
        end
        #2;
        rst_n = 1'b1;
        step();
        step();
        tests_run++;
        if ({obs_en, obs_idx, obs_busy, obs_done, obs_error} !== 14'h0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got en=%h idx=%0d busy=%b done=%b err=%b, expected all 0",
                     obs_en, obs_idx, obs_busy, obs_done, obs_error);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        drv_start = 1'b0;
        drv_abort = 1'b0;
        drv_valid = 8'h00;
        test_reset();
        run_frame("nominal", 0, 2, 16, 4, 6, 1'b0, 1'b0, 1'b0);
        run_frame("nominal_noise", 0, 2, 16, 4, 6, 1'b0, 1'b1, 1'b0);
        test_watchdog(1'b0, 0);
        test_watchdog(1'b1, int'($urandom_range(0, 20)));
        test_abort(7);
        run_frame("after_abort", 0, 2, 16, 4, 6, 1'b0, 1'b0, 1'b0);
        test_abort(15);
        test_abort(-5);
        run_frame("back_to_back_1", 0, 2, 16, 0, 0, 1'b1, 1'b1, 1'b1);
        run_frame("back_to_back_2", 0, 2, 16, 0, 0, 1'b1, 1'b1, 1'b1);
        run_frame("back_to_back_3", 0, 2, 16, 0, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) run_frame("random_2st", 0, 2, 16, 0, 0, 1'b1, 1'b1, 1'b0);
        test_continuous();
        for (int i = 0; i < 3; i++) run_frame("random_4st", 2, 4, 5, 0, 0, 1'b1, 1'b1, 1'b0);
        run_frame("no_watchdog_4st", 2, 4, 5, 70, 3, 1'b0, 1'b1, 1'b0);
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
